lsu_request_master: RTL and testbench
=====================================

# lsu_request_master

Initiator side of the memory-access stream interface. Accepts one load/store request at a time from the execute stage and computes the effective address. It drives the word-addressed memory stage over AXI-Stream address/data channels plus a 17-bit control word, then returns a sign/zero-extended load result or a store completion to writeback. Sub-word stores are done as read-modify-write, because the memory stage only writes full words.

## Interface
- ADDR_WORDS, 128: number of 32-bit words in the memory stage; word index ≥ ADDR_WORDS is an error
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- req_valid / req_ready  in/out  1  request handshake
- req_opcode  in  7  RISC-V opcode (0000011 load, 0100011 store)
- req_funct3  in  3  width/sign code
- req_base  in  32  rs1 value
- req_offset  in  32  sign-extended immediate
- req_wdata  in  32  rs2 value (stores)
- req_rd  in  5  destination register (loads)
- ctrl_data_o  out  17  {7'b0, funct3, opcode} to memory stage
- axis_m_addr_tvalid / tready / tdata  out/in/out  1/1/32  word index
- axis_m_data_tvalid / tready / tdata  out/in/out  1/1/32  store word
- axis_s_data_tvalid / tready / tdata  in/out/in  1/1/32  memory response
- wb_valid / wb_ready  out/in  1  completion handshake
- wb_we  out  1  1 = load result to write to wb_rd
- wb_rd  out  5  destination register
- wb_data  out  32  extended load value, 0 for stores
- wb_err  out  1  misaligned, out-of-range or illegal request

## Operation
- ea = req_base + req_offset, modulo 2^32. Word index = {2'b0, ea[31:2]}. Byte lane = ea[1:0]. All are latched on request accept.
- Error checks at accept:
  - opcode is neither load nor store.
  - Load funct3 not in {0,1,2,4,5}; store funct3 not in {0,1,2}.
  - Halfword with ea[0]=1; word with ea[1:0]≠0.
  - Word index ≥ ADDR_WORDS.
  - On error: go directly to RESP with wb_err=1, wb_we=0, wb_data=0. No memory traffic.
- FSM states: IDLE, RD, WR, RESP.
  - IDLE: req_ready=1. On req_valid: load or SB/SH → RD; SW → WR; error → RESP.
  - RD: ctrl_data_o = {7'b0, 3'b010, 7'b0000011}; addr_tvalid=1; data_tvalid=0; axis_s_data_tready=1.
    - On axis_s_data_tvalid & addr_tready: capture tdata. Load → RESP. SB/SH → WR, storing the merged word.
    - Merge rules: SB replaces bits [8·lane+7:8·lane] with req_wdata[7:0]. SH replaces [16·ea[1]+15:16·ea[1]] with req_wdata[15:0].
  - WR: ctrl_data_o = store opcode with latched funct3; addr_tvalid=1; data_tvalid=1; data tdata = merged word (SW: req_wdata).
    - Leave to RESP in the first cycle where addr_tready & data_tready.
    - ctrl_data_o carries the store opcode only while in WR.
  - RESP: wb_valid=1. Return to IDLE when wb_ready.
- Load extraction from captured word w:
  - LB: sign-extend w[8·lane+7 -: 8]. LBU: zero-extend the same byte.
  - LH: sign-extend the halfword at ea[1]. LHU: zero-extend it.
  - LW: w.
  - wb_we=1, wb_rd=latched rd.
- Stores complete with wb_we=0, wb_data=0, wb_rd=0.
- ctrl_data_o = 0 in IDLE and RESP. The memory stage writes whenever it sees a store opcode, so no store opcode may appear outside WR.

## Timing
- Reset (rst=0 at a clk edge): state=IDLE. In the same cycle and the cycle after, all tvalid=0, ctrl_data_o=0, wb_valid=0, wb_err=0, wb_we=0, wb_data=0, wb_rd=0, axis_s_data_tready=0. req_ready=1 after reset.
- Reset during RD/WR aborts the request. No store opcode is driven in the reset cycle, and no completion is produced.
- Outputs in each state are combinational decodes of the registered state and the latched request.
- The memory stage answers combinationally: a response arriving in the same cycle as the address is accepted in that cycle.
- Latency (accept edge = cycle 0, all readies high):
  - LW/LB/LH: RD in cycle 1, wb_valid in cycle 2.
  - SW: WR in cycle 1, wb_valid in cycle 2.
  - SB/SH: RD 1, WR 2, wb_valid 3.
  - Error: wb_valid in cycle 1.
- Back-pressure: RD and WR hold every output stable until the handshake. RESP holds wb_* stable until wb_ready.
- Throughput: one request in flight. req_ready=0 outside IDLE. A new request may be accepted the cycle after the RESP handshake.

## Test plan
- Memory model word 5 = 0x8000_00F0. LW, base=0x10, offset=4 → word index 5 on addr tdata in cycle 1; wb_valid cycle 2 with wb_data=0x8000_00F0, wb_we=1, wb_rd=req_rd.
- Same word, LB ea=0x14 → 0xFFFF_FFF0. LBU ea=0x14 → 0x0000_00F0. LH ea=0x16 → 0xFFFF_8000.
- Word 2 = 0x1122_3344. SB ea=0x09, wdata=0xAB → RD cycle sees load opcode; WR cycle has ctrl_data_o[6:0]=0100011 and data tdata=0x1122_AB44. Afterwards word 2 reads 0x1122_AB44. ctrl_data_o=0 in all other cycles.
- Misaligned LW ea=0x6, and LB with ea=4·ADDR_WORDS → wb_err=1 in cycle 1. addr_tvalid is never asserted and memory is unchanged.
- SW with addr_tready=0 for 3 cycles, then 1 → addr/data tdata and ctrl stable throughout; exactly one store cycle. wb_ready=0 for 2 cycles → wb_* held.
- rst=0 while in WR with tready=0 → ctrl_data_o=0 and tvalid=0 from the reset cycle; memory is unchanged and no wb_valid follows.

Source files
------------

// File: rtl/lsu_request_master.sv
// Load/store request master: computes the effective address, drives the word-addressed
// memory stage over AXI-Stream, merges sub-word stores (read-modify-write) and returns results.
module lsu_request_master #(
    parameter int unsigned ADDR_WORDS = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  req_opcode,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_base,
    input  logic [31:0] req_offset,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic [16:0] ctrl_data_o,
    output logic        axis_m_addr_tvalid,
    input  logic        axis_m_addr_tready,
    output logic [31:0] axis_m_addr_tdata,
    output logic        axis_m_data_tvalid,
    input  logic        axis_m_data_tready,
    output logic [31:0] axis_m_data_tdata,
    input  logic        axis_s_data_tvalid,
    output logic        axis_s_data_tready,
    input  logic [31:0] axis_s_data_tdata,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_err
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RESP
    } state_t;

    state_t      state;
    logic [2:0]  funct3_q;
    logic        is_load_q;
    logic        err_q;
    logic [4:0]  rd_q;
    logic [1:0]  lane_q;
    logic [29:0] widx_q;
    logic [31:0] word_q;
    logic [31:0] rdata_q;

    logic [31:0] ea;
    logic        acc_load;
    logic        acc_store;
    logic        f3_ok;
    logic        misalign;
    logic        out_of_range;
    logic        acc_err;

    // Replace the addressed byte/halfword of mem_word with the low bits of src.
    function automatic logic [31:0] merge_word(input logic [31:0] mem_word,
                                               input logic [31:0] src,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane);
        logic [4:0]  sh;
        logic [31:0] mask;
        logic [31:0] ins;
        if (size == 2'd0) begin
            sh   = {lane, 3'b000};
            mask = 32'h0000_00FF << sh;
            ins  = {24'h0, src[7:0]} << sh;
        end else if (size == 2'd1) begin
            sh   = {lane[1], 4'b0000};
            mask = 32'h0000_FFFF << sh;
            ins  = {16'h0, src[15:0]} << sh;
        end else begin
            mask = '1;
            ins  = src;
        end
        return (mem_word & ~mask) | (ins & mask);
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] w,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] sw;
        sw = w >> {lane, 3'b000};
        b  = sw[7:0];
        h  = lane[1] ? w[31:16] : w[15:0];
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd4:    return {24'h0, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd5:    return {16'h0, h};
            default: return w;
        endcase
    endfunction

    always_comb begin
        ea           = req_base + req_offset;
        acc_load     = (req_opcode == OP_LOAD);
        acc_store    = (req_opcode == OP_STORE);
        f3_ok        = acc_load ? (req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
                                : (req_funct3 inside {3'd0, 3'd1, 3'd2});
        misalign     = ((req_funct3[1:0] == 2'd1) && ea[0]) ||
                       ((req_funct3[1:0] == 2'd2) && (ea[1:0] != 2'b00));
        out_of_range = ({2'b00, ea[31:2]} >= 32'(ADDR_WORDS));
        acc_err      = !(acc_load || acc_store) || !f3_ok || misalign || out_of_range;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            funct3_q  <= '0;
            is_load_q <= 1'b0;
            err_q     <= 1'b0;
            rd_q      <= '0;
            lane_q    <= '0;
            widx_q    <= '0;
            word_q    <= '0;
            rdata_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        funct3_q  <= req_funct3;
                        is_load_q <= acc_load;
                        err_q     <= acc_err;
                        rd_q      <= req_rd;
                        lane_q    <= ea[1:0];
                        widx_q    <= ea[31:2];
                        word_q    <= req_wdata;
                        rdata_q   <= '0;
                        if (acc_err)
                            state <= S_RESP;
                        else if (acc_store && req_funct3[1:0] == 2'd2)
                            state <= S_WR;
                        else
                            state <= S_RD;
                    end
                end
                S_RD: begin
                    if (axis_s_data_tvalid && axis_m_addr_tready) begin
                        if (is_load_q) begin
                            rdata_q <= load_extract(axis_s_data_tdata, funct3_q, lane_q);
                            state   <= S_RESP;
                        end else begin
                            // word_q still holds rs2 here; it becomes the merged store word
                            word_q <= merge_word(axis_s_data_tdata, word_q, funct3_q[1:0], lane_q);
                            state  <= S_WR;
                        end
                    end
                end
                S_WR: begin
                    if (axis_m_addr_tready && axis_m_data_tready)
                        state <= S_RESP;
                end
                S_RESP: begin
                    if (wb_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs are gated by rst so nothing (especially a store opcode) leaks in the reset cycle.
    always_comb begin
        req_ready          = 1'b0;
        ctrl_data_o        = '0;
        axis_m_addr_tvalid = 1'b0;
        axis_m_addr_tdata  = '0;
        axis_m_data_tvalid = 1'b0;
        axis_m_data_tdata  = '0;
        axis_s_data_tready = 1'b0;
        wb_valid           = 1'b0;
        wb_we              = 1'b0;
        wb_rd              = '0;
        wb_data            = '0;
        wb_err             = 1'b0;
        if (rst) begin
            case (state)
                S_IDLE: req_ready = 1'b1;
                S_RD: begin
                    ctrl_data_o        = {7'b0, 3'b010, OP_LOAD};
                    axis_m_addr_tvalid = 1'b1;
                    axis_m_addr_tdata  = {2'b00, widx_q};
                    axis_s_data_tready = 1'b1;
                end
                S_WR: begin
                    ctrl_data_o        = {7'b0, funct3_q, OP_STORE};
                    axis_m_addr_tvalid = 1'b1;
                    axis_m_addr_tdata  = {2'b00, widx_q};
                    axis_m_data_tvalid = 1'b1;
                    axis_m_data_tdata  = word_q;
                end
                S_RESP: begin
                    wb_valid = 1'b1;
                    wb_err   = err_q;
                    wb_we    = is_load_q && !err_q;
                    wb_rd    = (is_load_q && !err_q) ? rd_q : 5'd0;
                    wb_data  = rdata_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_request_master.sv
// Scoreboard bench for lsu_request_master with a combinational word-addressed memory model.
module tb_lsu_request_master;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  req_opcode;
    logic [2:0]  req_funct3;
    logic [31:0] req_base;
    logic [31:0] req_offset;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic [16:0] ctrl_data_o;
    logic        axis_m_addr_tvalid;
    logic        axis_m_addr_tready;
    logic [31:0] axis_m_addr_tdata;
    logic        axis_m_data_tvalid;
    logic        axis_m_data_tready;
    logic [31:0] axis_m_data_tdata;
    logic        axis_s_data_tvalid;
    logic        axis_s_data_tready;
    logic [31:0] axis_s_data_tdata;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_err;

    lsu_request_master #(.ADDR_WORDS(128)) dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_opcode         (req_opcode),
        .req_funct3         (req_funct3),
        .req_base           (req_base),
        .req_offset         (req_offset),
        .req_wdata          (req_wdata),
        .req_rd             (req_rd),
        .ctrl_data_o        (ctrl_data_o),
        .axis_m_addr_tvalid (axis_m_addr_tvalid),
        .axis_m_addr_tready (axis_m_addr_tready),
        .axis_m_addr_tdata  (axis_m_addr_tdata),
        .axis_m_data_tvalid (axis_m_data_tvalid),
        .axis_m_data_tready (axis_m_data_tready),
        .axis_m_data_tdata  (axis_m_data_tdata),
        .axis_s_data_tvalid (axis_s_data_tvalid),
        .axis_s_data_tready (axis_s_data_tready),
        .axis_s_data_tdata  (axis_s_data_tdata),
        .wb_valid           (wb_valid),
        .wb_ready           (wb_ready),
        .wb_we              (wb_we),
        .wb_rd              (wb_rd),
        .wb_data            (wb_data),
        .wb_err             (wb_err)
    );

    always #5 clk = ~clk;

    // Memory stage model: answers loads combinationally, writes on any store-opcode handshake.
    logic [31:0] mem [0:127];
    bit          mem_init_done = 1'b0;

    assign axis_s_data_tvalid = axis_m_addr_tvalid && (ctrl_data_o[6:0] == OP_LOAD);
    assign axis_s_data_tdata  = (axis_m_addr_tdata < 32'd128) ? mem[axis_m_addr_tdata[6:0]]
                                                              : 32'hDEAD_DEAD;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
            mem[2] <= 32'h1122_3344;
            mem[4] <= 32'hA5A5_A5A5;
            mem[5] <= 32'h8000_00F0;
            mem_init_done <= 1'b1;
        end else if (ctrl_data_o[6:0] == OP_STORE && axis_m_addr_tready && axis_m_data_tready &&
                     axis_m_addr_tdata < 32'd128) begin
            mem[axis_m_addr_tdata[6:0]] <= axis_m_data_tdata;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        err;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_av = 0;
    int   n_st = 0;

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (axis_m_addr_tvalid) n_av++;
        if (ctrl_data_o[6:0] == OP_STORE && axis_m_addr_tready && axis_m_data_tready) n_st++;
        if (rst && wb_valid && wb_ready) begin
            if (sb.size() == 0) begin
                check("wb_unexpected", {31'h0, wb_valid}, 32'h0);
            end else begin
                e = sb.pop_front();
                check("wb_err", {31'h0, wb_err}, {31'h0, e.err});
                check("wb_we", {31'h0, wb_we}, {31'h0, e.we});
                check("wb_rd", {27'h0, wb_rd}, {27'h0, e.rd});
                check("wb_data", wb_data, e.data);
            end
        end
    end

    logic [16:0] tr_ctrl [0:31];
    logic        tr_av   [0:31];
    logic [31:0] tr_addr [0:31];
    logic [31:0] tr_wd   [0:31];

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] base,
                         input logic [31:0] off, input logic [31:0] wd, input logic [4:0] rd,
                         input logic e_err, input logic e_we, input logic [31:0] e_data,
                         input int unsigned exp_lat, input int unsigned ar_stall,
                         input int unsigned wb_stall);
        exp_t        e;
        int unsigned lat;
        bit          got;
        logic [31:0] snap_d;
        logic [6:0]  snap_c;
        @(negedge clk);
        check("req_ready", {31'h0, req_ready}, 32'h1);
        req_opcode = op;  req_funct3 = f3; req_base = base;
        req_offset = off; req_wdata = wd;  req_rd = rd;
        req_valid  = 1'b1;
        e.err = e_err; e.we = e_we; e.rd = e_we ? rd : 5'd0; e.data = e_data;
        sb.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 30) begin
            @(negedge clk);
            lat++;
            axis_m_addr_tready = (lat > ar_stall);
            tr_ctrl[lat] = ctrl_data_o;
            tr_av[lat]   = axis_m_addr_tvalid;
            tr_addr[lat] = axis_m_addr_tdata;
            tr_wd[lat]   = axis_m_data_tdata;
            if (wb_valid) got = 1'b1;
        end
        check("latency", lat, exp_lat);
        if (got) begin
            snap_d   = wb_data;
            snap_c   = {wb_err, wb_we, wb_rd};
            wb_ready = (wb_stall == 0);
            for (int unsigned k = 0; k < wb_stall; k++) begin
                @(negedge clk);
                check("wb_hold_valid", {31'h0, wb_valid}, 32'h1);
                check("wb_hold_data", wb_data, snap_d);
                check("wb_hold_ctl", {25'h0, wb_err, wb_we, wb_rd}, {25'h0, snap_c});
                if (k == wb_stall - 1) wb_ready = 1'b1;
            end
        end
        @(posedge clk);
        #1 axis_m_addr_tready = 1'b1;
        wb_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int av0;
        int st0;
        rst = 1'b0; req_valid = 1'b0;
        req_opcode = '0; req_funct3 = '0; req_base = '0; req_offset = '0;
        req_wdata = '0; req_rd = '0;
        axis_m_addr_tready = 1'b1; axis_m_data_tready = 1'b1; wb_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_ctrl", {15'h0, ctrl_data_o}, 32'h0);
        check("rst_tvalid", {30'h0, axis_m_addr_tvalid, axis_m_data_tvalid}, 32'h0);
        check("rst_wb", {28'h0, wb_valid, wb_err, wb_we, axis_s_data_tready}, 32'h0);
        check("rst_wb_data", wb_data, 32'h0);
        check("rst_wb_rd", {27'h0, wb_rd}, 32'h0);
        rst = 1'b1;

        // Loads from word 5 = 0x8000_00F0
        issue(OP_LOAD, 3'd2, 32'h10, 32'h4, 32'h0, 5'd7, 1'b0, 1'b1, 32'h8000_00F0, 2, 0, 0);
        check("lw_addr", tr_addr[1], 32'd5);
        check("lw_av", {31'h0, tr_av[1]}, 32'h1);
        issue(OP_LOAD, 3'd0, 32'h14, 32'h0, 32'h0, 5'd3, 1'b0, 1'b1, 32'hFFFF_FFF0, 2, 0, 0);
        issue(OP_LOAD, 3'd4, 32'h14, 32'h0, 32'h0, 5'd4, 1'b0, 1'b1, 32'h0000_00F0, 2, 0, 0);
        issue(OP_LOAD, 3'd1, 32'h20, 32'hFFFF_FFF6, 32'h0, 5'd5, 1'b0, 1'b1, 32'hFFFF_8000, 2, 0, 0);
        issue(OP_LOAD, 3'd5, 32'h16, 32'h0, 32'h0, 5'd6, 1'b0, 1'b1, 32'h0000_8000, 2, 0, 0);

        // SB into word 2, then read back
        st0 = n_st;
        issue(OP_STORE, 3'd0, 32'h9, 32'h0, 32'hDEAD_BEAB, 5'd1, 1'b0, 1'b0, 32'h0, 3, 0, 0);
        #3;
        check("sb_rd_ctrl", {15'h0, tr_ctrl[1]}, 32'h0000_0103);
        check("sb_wr_ctrl", {15'h0, tr_ctrl[2]}, 32'h0000_0023);
        check("sb_wdata", tr_wd[2], 32'h1122_AB44);
        check("sb_resp_ctrl", {15'h0, tr_ctrl[3]}, 32'h0);
        check("sb_store_cnt", n_st - st0, 1);
        issue(OP_LOAD, 3'd2, 32'h8, 32'h0, 32'h0, 5'd2, 1'b0, 1'b1, 32'h1122_AB44, 2, 0, 0);

        // SH into upper half of word 2
        issue(OP_STORE, 3'd1, 32'hA, 32'h0, 32'h0000_5566, 5'd1, 1'b0, 1'b0, 32'h0, 3, 0, 0);
        check("sh_wr_ctrl", {15'h0, tr_ctrl[2]}, 32'h0000_00A3);
        issue(OP_LOAD, 3'd2, 32'h4, 32'h4, 32'h0, 5'd8, 1'b0, 1'b1, 32'h5566_AB44, 2, 0, 0);

        // Error requests: no memory traffic
        av0 = n_av; st0 = n_st;
        issue(OP_LOAD, 3'd2, 32'h6, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0, 32'h0, 1, 0, 0);
        issue(OP_LOAD, 3'd0, 32'h200, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0, 32'h0, 1, 0, 0);
        issue(7'b0110011, 3'd0, 32'h0, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0, 32'h0, 1, 0, 0);
        issue(OP_STORE, 3'd4, 32'h0, 32'h0, 32'hFFFF_FFFF, 5'd9, 1'b1, 1'b0, 32'h0, 1, 0, 0);
        issue(OP_LOAD, 3'd1, 32'h15, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0, 32'h0, 1, 0, 0);
        #3;
        check("err_no_addr", n_av - av0, 0);
        check("err_no_store", n_st - st0, 0);
        check("err_mem0", mem[0], 32'h0);

        // SW with address back-pressure and writeback back-pressure
        st0 = n_st;
        issue(OP_STORE, 3'd2, 32'hC, 32'h0, 32'hCAFE_F00D, 5'd9, 1'b0, 1'b0, 32'h0, 5, 3, 2);
        #3;
        for (int k = 1; k <= 4; k++) begin
            check("sw_addr_stable", tr_addr[k], 32'd3);
            check("sw_data_stable", tr_wd[k], 32'hCAFE_F00D);
            check("sw_ctrl_stable", {15'h0, tr_ctrl[k]}, 32'h0000_0123);
        end
        check("sw_store_cnt", n_st - st0, 1);
        check("sw_mem", mem[3], 32'hCAFE_F00D);

        // Reset while a SW to word 4 is stalled in WR
        st0 = n_st;
        @(negedge clk);
        axis_m_addr_tready = 1'b0;
        req_opcode = OP_STORE; req_funct3 = 3'd2; req_base = 32'h10; req_offset = 32'h0;
        req_wdata = 32'h1234_5678; req_rd = 5'd0; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("wr_before_rst", {15'h0, ctrl_data_o}, 32'h0000_0123);
        rst = 1'b0;
        axis_m_addr_tready = 1'b1;
        #1;
        check("rstwr_ctrl", {15'h0, ctrl_data_o}, 32'h0);
        check("rstwr_tvalid", {30'h0, axis_m_addr_tvalid, axis_m_data_tvalid}, 32'h0);
        @(negedge clk);
        check("rstwr_ctrl2", {15'h0, ctrl_data_o}, 32'h0);
        check("rstwr_wb", {31'h0, wb_valid}, 32'h0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        #3;
        check("rstwr_mem", mem[4], 32'hA5A5_A5A5);
        check("rstwr_store_cnt", n_st - st0, 0);
        issue(OP_LOAD, 3'd2, 32'h10, 32'h0, 32'h0, 5'd10, 1'b0, 1'b1, 32'hA5A5_A5A5, 2, 0, 0);

        repeat (3) @(negedge clk);
        #3;
        check("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
